video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Raster timing source that drives the pixel counters consumed by the sprite and overlay blocks, such as ball-type renderers that compare their position against hcnt/vcnt.
- Generates o_hcnt/o_vcnt, hsync, vsync and data-enable for a parameterised video mode; default is 640x480@60 (800x525 total).
- Sits between the pixel clock domain and the TMDS encoder/serializer path; sprite blocks and the encoder share its outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- i_pix_en  in  1  pixel advance enable; tie high for one pixel per clk
- o_hcnt  out  11  current pixel column, 0..H_TOTAL-1
- o_vcnt  out  11  current line, 0..V_TOTAL-1
- o_de  out  1  high inside the active area
- o_hsync  out  1  horizontal sync, polarity set by HS_POL
- o_vsync  out  1  vertical sync, polarity set by VS_POL
- o_line_start  out  1  one-cycle pulse when o_hcnt==0
- o_frame_start  out  1  one-cycle pulse when o_hcnt==0 and o_vcnt==0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤2048; elaboration fails otherwise.
- Reset (asynchronous assert, synchronous release):
  - internal counters h=0, v=0; H FSM = H_ACT; V FSM = V_ACT
  - outputs: o_hcnt=0, o_vcnt=0, o_de=0, o_hsync=~HS_POL, o_vsync=~VS_POL, o_line_start=0, o_frame_start=0
- Pipeline: internal counters, then registered decode, then outputs. All outputs come from one register stage and are mutually coherent: o_de, syncs and pulses always describe the position shown on o_hcnt/o_vcnt.
- First i_pix_en=1 edge after reset release presents position (0,0): o_de=1, o_line_start=1, o_frame_start=1.
- i_pix_en=0: every register holds, pulses included. A pulse lasts exactly one enabled cycle.
- H FSM (advances per enabled cycle):
  - H_ACT → H_FP at h==H_ACTIVE-1
  - H_FP → H_SYNC at h==H_ACTIVE+H_FP-1
  - H_SYNC → H_BP at h==H_ACTIVE+H_FP+H_SYNC-1
  - H_BP → H_ACT at h==H_TOTAL-1, where h wraps to 0
- V FSM: same state/transition structure on v, evaluated only on the enabled cycle where h==H_TOTAL-1. v wraps to 0 after V_TOTAL-1.
- o_hsync = HS_POL while o_hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- o_vsync = VS_POL for whole lines in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only together with o_hcnt going to 0.
- o_de = (o_hcnt<H_ACTIVE) && (o_vcnt<V_ACTIVE).
- Zero-length porch: any porch parameter may be 0; that FSM state is skipped with no dead cycle. H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be ≥1.
- Mid-frame reset: outputs return to reset values immediately (async). Restart is at (0,0), with no partial-frame pulses.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- Defined: adds output o_frame_cnt (16 bits). Reset value 0; increments on the same enabled cycle o_frame_start is asserted, so the first frame after reset reads 1. Wraps 0xFFFF→0. Sprite blocks can use it for animation pacing.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, i_pix_en=1, reset released: first enabled edge gives o_hcnt=0, o_vcnt=0, o_de=1, o_frame_start=1; next o_frame_start comes exactly 420000 cycles later.
- Defaults, one line: o_de high for 640 cycles; o_hsync low from o_hcnt=656 through 751 (96 cycles), high elsewhere; o_line_start every 800 cycles.
- Defaults, one frame: o_vsync low exactly while o_vcnt∈{490,491} (1600 cycles); o_de high for 307200 cycles per frame; o_vcnt wraps 524→0 coincident with o_hcnt 799→0.
- i_pix_en toggling 1,0,0,1…: counters and pulses hold on 0 cycles; a pulse seen on an enabled cycle stays high through the following disabled cycles and clears on the next enabled cycle. The frame period measured in enabled cycles is still 420000.
- Override H_ACTIVE=4,H_FP=0,H_SYNC=1,H_BP=1,V_ACTIVE=2,V_FP=0,V_SYNC=1,V_BP=0 with HS_POL=1: line 6 cycles, hsync high only at o_hcnt=4, vsync high only on line 2, frame 18 cycles.
- resetn pulsed low at o_hcnt=300, o_vcnt=200: outputs go to reset values without a clock edge; after release the sequence restarts at (0,0) with o_frame_start. With VIDEO_TIMING_FRAME_CNT_EN, o_frame_cnt reads 0 during reset and 1 after restart.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing source. Two free-running position counters
//                (h, v), each tracked by a region FSM (active / front porch /
//                sync / back porch). A second register stage turns them into
//                mutually coherent outputs.
//  Ports       : clk            pixel clock
//                resetn         asynchronous active-low reset
//                i_pix_en       pixel advance enable (all registers hold when 0)
//                o_hcnt/o_vcnt  position currently presented (11 bits each)
//                o_de           active-area flag for the presented position
//                o_hsync        horizontal sync, active level HS_POL
//                o_vsync        vertical sync, active level VS_POL
//                o_line_start   high while o_hcnt==0
//                o_frame_start  high while o_hcnt==0 and o_vcnt==0
//                o_frame_cnt    16-bit frame counter, only when the macro
//                               VIDEO_TIMING_FRAME_CNT_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_pix_en,
    output logic [10:0] o_hcnt,
    output logic [10:0] o_vcnt,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_line_start,
    output logic        o_frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   ,output logic [15:0] o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries are 12 bits wide so that an end value of 2048 still
    // compares correctly against an 11-bit position.
    localparam logic [11:0] c_H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] c_H_FP_END   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] c_V_FP_END   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
    localparam logic        c_HS_ACT     = 1'(HS_POL);
    localparam logic        c_VS_ACT     = 1'(VS_POL);

    generate
        if ((H_TOTAL > 2048) || (V_TOTAL > 2048) || (H_ACTIVE < 1) ||
            (V_ACTIVE < 1) || (H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_cfg
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_ACT  = 2'd0,
        S_FP   = 2'd1,
        S_SYNC = 2'd2,
        S_BP   = 2'd3
    } region_t;

    // The region is derived from the position the counter is moving to, so a
    // zero-length porch is simply never selected and costs no cycle.
    function automatic region_t region_of(input logic [10:0] pos,
                                          input logic [11:0] act_end,
                                          input logic [11:0] fp_end,
                                          input logic [11:0] sync_end);
        logic [11:0] p;
        p = {1'b0, pos};
        if (p < act_end)       return S_ACT;
        else if (p < fp_end)   return S_FP;
        else if (p < sync_end) return S_SYNC;
        else                   return S_BP;
    endfunction

    // ---------------------------------------------------------------- stage 1
    logic [10:0] r_h, r_v;
    region_t     r_hstate, r_vstate;
    logic        w_h_wrap, w_v_wrap;
    logic [10:0] w_h_next, w_v_next;
    region_t     w_hstate_next, w_vstate_next;

    always_comb begin
        w_h_wrap      = (r_h == c_H_LAST);
        w_v_wrap      = (r_v == c_V_LAST);
        w_h_next      = w_h_wrap ? 11'd0 : r_h + 11'd1;
        w_v_next      = w_v_wrap ? 11'd0 : r_v + 11'd1;
        w_hstate_next = region_of(w_h_next, c_H_ACT_END, c_H_FP_END, c_H_SYNC_END);
        w_vstate_next = region_of(w_v_next, c_V_ACT_END, c_V_FP_END, c_V_SYNC_END);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h      <= 11'd0;
            r_v      <= 11'd0;
            r_hstate <= S_ACT;
            r_vstate <= S_ACT;
        end else if (i_pix_en) begin
            r_h      <= w_h_next;
            r_hstate <= w_hstate_next;
            if (w_h_wrap) begin
                r_v      <= w_v_next;
                r_vstate <= w_vstate_next;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    // Every output is loaded from the same stage-1 snapshot, which keeps the
    // flags aligned with the position shown on o_hcnt/o_vcnt.
    logic [10:0] r_hcnt, r_vcnt;
    logic        r_de, r_hsync, r_vsync, r_line_start, r_frame_start;
    logic        w_origin;

    assign w_origin = (r_h == 11'd0) && (r_v == 11'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hcnt        <= 11'd0;
            r_vcnt        <= 11'd0;
            r_de          <= 1'b0;
            r_hsync       <= ~c_HS_ACT;
            r_vsync       <= ~c_VS_ACT;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            r_hcnt        <= r_h;
            r_vcnt        <= r_v;
            r_de          <= (r_hstate == S_ACT) && (r_vstate == S_ACT);
            r_hsync       <= (r_hstate == S_SYNC) ? c_HS_ACT : ~c_HS_ACT;
            r_vsync       <= (r_vstate == S_SYNC) ? c_VS_ACT : ~c_VS_ACT;
            r_line_start  <= (r_h == 11'd0);
            r_frame_start <= w_origin;
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    // Steps on the same edge that raises o_frame_start, so frame 1 reads 1.
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt <= 16'd0;
        end else if (i_pix_en && w_origin) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Directed self-checking bench. Instance A uses the default
//                640x480 mode (line level checks, mid-frame reset); instance B
//                uses a tiny 6x3 mode checked cycle by cycle against a
//                position model, including stalled (i_pix_en=0) cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pen_a, pen_b;

    logic [10:0] a_hcnt, a_vcnt, b_hcnt, b_vcnt;
    logic        a_de, a_hsync, a_vsync, a_ls, a_fs;
    logic        b_de, b_hsync, b_vsync, b_ls, b_fs;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] a_fcnt, b_fcnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    video_timing_gen u_dut_a (
        .clk           (clk),
        .resetn        (resetn),
        .i_pix_en      (pen_a),
        .o_hcnt        (a_hcnt),
        .o_vcnt        (a_vcnt),
        .o_de          (a_de),
        .o_hsync       (a_hsync),
        .o_vsync       (a_vsync),
        .o_line_start  (a_ls),
        .o_frame_start (a_fs)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
       ,.o_frame_cnt   (a_fcnt)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(0), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .HS_POL(1),   .VS_POL(1)
    ) u_dut_b (
        .clk           (clk),
        .resetn        (resetn),
        .i_pix_en      (pen_b),
        .o_hcnt        (b_hcnt),
        .o_vcnt        (b_vcnt),
        .o_de          (b_de),
        .o_hsync       (b_hsync),
        .o_vsync       (b_vsync),
        .o_line_start  (b_ls),
        .o_frame_start (b_fs)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
       ,.o_frame_cnt   (b_fcnt)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, pos_err, ls_err;
        int k, kl, mh, mv;
        bit en;

        resetn = 1'b0;
        pen_a  = 1'b0;
        pen_b  = 1'b0;
        repeat (3) tick();

        // ---------------- reset values
        chk("rst_hcnt",  int'(a_hcnt), 0);
        chk("rst_vcnt",  int'(a_vcnt), 0);
        chk("rst_de",    int'(a_de), 0);
        chk("rst_hsync", int'(a_hsync), 1);
        chk("rst_vsync", int'(a_vsync), 1);
        chk("rst_ls",    int'(a_ls), 0);
        chk("rst_fs",    int'(a_fs), 0);
        chk("rst_b_hsync", int'(b_hsync), 0);
        chk("rst_b_vsync", int'(b_vsync), 0);

        // Released but disabled: nothing moves.
        resetn = 1'b1;
        repeat (2) tick();
        chk("idle_de", int'(a_de), 0);
        chk("idle_fs", int'(a_fs), 0);

        // ---------------- default mode, first line
        pen_a = 1'b1;
        tick();
        chk("first_hcnt", int'(a_hcnt), 0);
        chk("first_vcnt", int'(a_vcnt), 0);
        chk("first_de",   int'(a_de), 1);
        chk("first_ls",   int'(a_ls), 1);
        chk("first_fs",   int'(a_fs), 1);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("first_fcnt", int'(a_fcnt), 1);
`endif
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        pos_err = 0; ls_err = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            if (a_de) de_cnt++;
            if (!a_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a_hcnt);
                hs_last = int'(a_hcnt);
            end
            if (int'(a_hcnt) != i || a_vcnt != 11'd0) pos_err++;
            if (a_ls != (i == 0)) ls_err++;
            if (a_de != (i < 640)) pos_err++;
        end
        chk("line_de_cycles",  de_cnt, 640);
        chk("line_hs_cycles",  hs_cnt, 96);
        chk("line_hs_first",   hs_first, 656);
        chk("line_hs_last",    hs_last, 751);
        chk("line_pos_errors", pos_err, 0);
        chk("line_ls_errors",  ls_err, 0);
        tick();
        chk("line2_hcnt", int'(a_hcnt), 0);
        chk("line2_vcnt", int'(a_vcnt), 1);
        chk("line2_ls",   int'(a_ls), 1);
        chk("line2_fs",   int'(a_fs), 0);
        chk("line2_vsync", int'(a_vsync), 1);
        pen_a = 1'b0;

        // ---------------- tiny mode: 2 full frames, then 1,0,0 enable pattern
        k  = 0;
        kl = 0;
        for (int c = 0; c < 90; c++) begin
            en    = (c < 36) ? 1'b1 : ((c % 3) == 0);
            pen_b = en;
            tick();
            if (en) begin
                kl = k;
                k++;
            end
            mh = kl % 6;
            mv = (kl / 6) % 3;
            chk($sformatf("b_hcnt@%0d", c),  int'(b_hcnt), mh);
            chk($sformatf("b_vcnt@%0d", c),  int'(b_vcnt), mv);
            chk($sformatf("b_de@%0d", c),    int'(b_de), (mh < 4 && mv < 2) ? 1 : 0);
            chk($sformatf("b_hsync@%0d", c), int'(b_hsync), (mh == 4) ? 1 : 0);
            chk($sformatf("b_vsync@%0d", c), int'(b_vsync), (mv == 2) ? 1 : 0);
            chk($sformatf("b_ls@%0d", c),    int'(b_ls), (mh == 0) ? 1 : 0);
            chk($sformatf("b_fs@%0d", c),    int'(b_fs), (mh == 0 && mv == 0) ? 1 : 0);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
            chk($sformatf("b_fcnt@%0d", c),  int'(b_fcnt), kl / 18 + 1);
`endif
        end
        pen_b = 1'b0;

        // ---------------- mid-frame asynchronous reset on instance A
        pen_a = 1'b1;
        for (int i = 0; i < 3000 && !(a_hcnt == 11'd300 && a_vcnt == 11'd2); i++) tick();
        chk("mid_reach_hcnt", int'(a_hcnt), 300);
        chk("mid_reach_vcnt", int'(a_vcnt), 2);
        resetn = 1'b0;
        #2;
        chk("mid_rst_hcnt",  int'(a_hcnt), 0);
        chk("mid_rst_vcnt",  int'(a_vcnt), 0);
        chk("mid_rst_de",    int'(a_de), 0);
        chk("mid_rst_hsync", int'(a_hsync), 1);
        chk("mid_rst_ls",    int'(a_ls), 0);
        chk("mid_rst_fs",    int'(a_fs), 0);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("mid_rst_fcnt",  int'(a_fcnt), 0);
`endif
        repeat (2) tick();
        chk("mid_hold_hcnt", int'(a_hcnt), 0);
        chk("mid_hold_de",   int'(a_de), 0);
        resetn = 1'b1;
        tick();
        chk("restart_hcnt", int'(a_hcnt), 0);
        chk("restart_vcnt", int'(a_vcnt), 0);
        chk("restart_fs",   int'(a_fs), 1);
        chk("restart_de",   int'(a_de), 1);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        chk("restart_fcnt", int'(a_fcnt), 1);
`endif
        tick();
        chk("restart2_hcnt", int'(a_hcnt), 1);
        chk("restart2_fs",   int'(a_fs), 0);
        chk("restart2_ls",   int'(a_ls), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
